// File: rtl/csr_mc_pkg.sv
// rtl/csr_mc_pkg.sv - shared address map, bit indices and engine state type
package csr_mc_pkg;

  // Per-channel register offsets inside a 0x20-byte window
  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_STATUS   = 5'h04;
  localparam logic [4:0] OFF_CONFIG   = 5'h08;
  localparam logic [4:0] OFF_DATA_IN  = 5'h0C;
  localparam logic [4:0] OFF_DATA_OUT = 5'h10;

  // Global read-only registers
  localparam logic [7:0] ADDR_CAPS    = 8'hF8;
  localparam logic [7:0] ADDR_VERSION = 8'hFC;

  // CTRL bits
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_IE    = 2;

  // STATUS bits
  localparam int STS_DONE = 0;
  localparam int STS_BUSY = 1;
  localparam int STS_ERR  = 2;

  // Read data returned for unmapped addresses
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  typedef enum logic {ST_IDLE, ST_RUN} eng_state_t;

endpackage

// File: rtl/csr_mc_channel.sv
// rtl/csr_mc_channel.sv - one channel: CTRL/STATUS/CONFIG/DATA registers and accumulate engine
module csr_mc_channel
  import csr_mc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en_i,
  input  logic [4:0]  wr_off_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_off_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        ie_o
);

  localparam int SUM_W = DATA_W + 1;

  eng_state_t         state_q;
  logic               ie_q, done_q, err_q;
  logic [CNT_W-1:0]   limit_q, lim_q, cnt_q;
  logic [DATA_W-1:0]  data_in_q, data_out_q, buf_q;
  logic [SUM_W-1:0]   sum;
  logic               wr_ctrl, wr_stat, wr_cfg, wr_din;
  logic               start_req, abort_req, run_live, set_done, set_err;

  assign wr_ctrl = wr_en_i && (wr_off_i == OFF_CTRL);
  assign wr_stat = wr_en_i && (wr_off_i == OFF_STATUS);
  assign wr_cfg  = wr_en_i && (wr_off_i == OFF_CONFIG);
  assign wr_din  = wr_en_i && (wr_off_i == OFF_DATA_IN);

  // ABORT beats START when both arrive in one write
  assign start_req = wr_ctrl && wdata_i[CTRL_START] && !wdata_i[CTRL_ABORT];
  assign abort_req = wr_ctrl && wdata_i[CTRL_ABORT];

  assign sum      = {1'b0, buf_q} + SUM_W'(cnt_q);
  assign run_live = (state_q == ST_RUN) && !abort_req;
  // Carry outranks completion
  assign set_err  = run_live && sum[DATA_W];
  assign set_done = run_live && !sum[DATA_W] && (cnt_q == lim_q);

  // Host registers; a hardware set of DONE/ERR wins over a same-cycle W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ie_q      <= 1'b0;
      limit_q   <= '0;
      data_in_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (wr_ctrl) ie_q <= wdata_i[CTRL_IE];
      if (wr_cfg)  limit_q <= wdata_i[CNT_W-1:0];
      if (wr_din)  data_in_q <= wdata_i[DATA_W-1:0];
      done_q <= set_done | (done_q & ~(wr_stat & wdata_i[STS_DONE]));
      err_q  <= set_err  | (err_q  & ~(wr_stat & wdata_i[STS_ERR]));
    end
  end

  // Engine FSM: capture operands on START, accumulate one step per RUN cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      lim_q      <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_req && !err_q) begin
            state_q <= ST_RUN;
            buf_q   <= data_in_q;
            lim_q   <= limit_q;
            cnt_q   <= '0;
          end
        end
        ST_RUN: begin
          if (abort_req) begin
            state_q <= ST_IDLE;
          end else begin
            data_out_q <= sum[DATA_W-1:0];
            if (sum[DATA_W] || (cnt_q == lim_q)) state_q <= ST_IDLE;
            else cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read-back mux for this channel's window
  always_comb begin
    rdata_o = '0;
    case (rd_off_i)
      OFF_CTRL:     rdata_o[CTRL_IE] = ie_q;
      OFF_STATUS: begin
        rdata_o[STS_DONE] = done_q;
        rdata_o[STS_BUSY] = (state_q == ST_RUN);
        rdata_o[STS_ERR]  = err_q;
      end
      OFF_CONFIG:   rdata_o = 32'(limit_q);
      OFF_DATA_IN:  rdata_o = 32'(data_in_q);
      OFF_DATA_OUT: rdata_o = 32'(data_out_q);
      default:      rdata_o = '0;
    endcase
  end

  assign done_o = done_q;
  assign err_o  = err_q;
  assign ie_o   = ie_q;

endmodule

// File: rtl/csr_mc_engine.sv
// rtl/csr_mc_engine.sv - multi-channel CSR block: decode, registered read, err pulse, merged irq
module csr_mc_engine
  import csr_mc_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          DATA_W  = 32,
  parameter int          CNT_W   = 8,
  parameter logic [31:0] VERSION = 32'h0002_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err,
  output logic        irq
);

  localparam logic [31:0] CAPS = {8'(NUM_CH), 8'(DATA_W), 8'(CNT_W), 8'h00};

  logic [2:0]        ch_idx;
  logic [4:0]        off;
  logic              is_ch, off_ok, hit_caps, hit_ver, mapped, ro_hit;
  logic [31:0]       ch_rdata [NUM_CH];
  logic [NUM_CH-1:0] ch_wr, ch_done, ch_err, ch_ie;
  logic [31:0]       rd_word;
  logic [31:0]       rdata_q;
  logic              rvalid_q, err_q, irq_q;

  assign ch_idx   = addr[7:5];
  assign off      = addr[4:0];
  assign is_ch    = int'(ch_idx) < NUM_CH;
  assign off_ok   = off inside {OFF_CTRL, OFF_STATUS, OFF_CONFIG, OFF_DATA_IN, OFF_DATA_OUT};
  assign hit_caps = (addr == ADDR_CAPS);
  assign hit_ver  = (addr == ADDR_VERSION);
  assign mapped   = (is_ch && off_ok) || hit_caps || hit_ver;
  assign ro_hit   = (is_ch && off == OFF_DATA_OUT) || hit_caps || hit_ver;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_wr[c] = wr_en && mapped && !ro_hit && (ch_idx == 3'(c));
    csr_mc_channel #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en_i  (ch_wr[c]),
      .wr_off_i (off),
      .wdata_i  (wdata),
      .rd_off_i (off),
      .rdata_o  (ch_rdata[c]),
      .done_o   (ch_done[c]),
      .err_o    (ch_err[c]),
      .ie_o     (ch_ie[c])
    );
  end

  // Select the word a read at addr would return this cycle
  always_comb begin
    rd_word = DEAD_BEEF;
    if (hit_caps) rd_word = CAPS;
    else if (hit_ver) rd_word = VERSION;
    else if (is_ch && off_ok) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == 3'(c)) rd_word = ch_rdata[c];
      end
    end
  end

  // Registered read response, error pulse and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) rdata_q <= rd_word;
      err_q <= ((rd_en || wr_en) && !mapped) || (wr_en && ro_hit);
      irq_q <= |(ch_ie & (ch_done | ch_err));
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_csr_mc_engine.sv
// tb/tb_csr_mc_engine.sv - scoreboard bench for csr_mc_engine
module tb_csr_mc_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rdata;
  logic        rvalid, err, irq;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] d;
    string       n;
  } rexp_t;

  rexp_t exp_rd[$];
  logic  exp_err[$];

  csr_mc_engine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .wdata   (wdata),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .err     (err),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle; expectations are queued for the monitor
  task automatic acc(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic [31:0] exp_d, input logic exp_e, input string name);
    addr  = a;
    wdata = d;
    rd_en = r;
    wr_en = w;
    if (r) exp_rd.push_back('{d: exp_d, n: name});
    exp_err.push_back(exp_e);
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp_d, input string name);
    acc(1'b1, 1'b0, a, 32'h0, exp_d, 1'b0, name);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    acc(1'b0, 1'b1, a, d, 32'h0, 1'b0, "wr");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops expectations whenever the DUT responds
  initial begin
    logic rd_seen, acc_seen;
    rexp_t e;
    logic ee;
    forever begin
      @(posedge clk);
      rd_seen  = rd_en && reset_n;
      acc_seen = (rd_en || wr_en) && reset_n;
      @(negedge clk);
      if (reset_n) begin
        if (rd_seen || rvalid) check("rvalid_timing", 32'(rvalid), 32'(rd_seen));
        if (rvalid) begin
          if (exp_rd.size() == 0) check("unexpected_rvalid", 32'(rvalid), 32'h0);
          else begin
            e = exp_rd.pop_front();
            check(e.n, rdata, e.d);
          end
        end
        if (acc_seen) begin
          if (exp_err.size() == 0) check("err_queue_empty", 32'(exp_err.size()), 32'h1);
          else begin
            ee = exp_err.pop_front();
            check("err_pulse", 32'(err), 32'(ee));
          end
        end else if (err) begin
          check("spurious_err", 32'(err), 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] offs [5];
    offs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10};

    // 1. reset values
    idle(3);
    check("reset_rdata", rdata, 32'h0);
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++)
      for (int o = 0; o < 5; o++)
        rd(8'(c * 32) + 8'(offs[o]), 32'h0, "reset_reg");
    rd(8'hF8, 32'h0420_0800, "caps");
    rd(8'hFC, 32'h0002_0000, "version");

    // 2. ch1 normal completion with interrupt
    wr(8'h20, 32'h4);
    wr(8'h2C, 32'h100);
    wr(8'h28, 32'h3);
    wr(8'h20, 32'h5);
    repeat (4) rd(8'h24, 32'h2, "ch1_busy");
    rd(8'h24, 32'h1, "ch1_done");
    rd(8'h30, 32'h103, "ch1_data_out");
    rd(8'h20, 32'h4, "ch1_ctrl_selfclear");
    check("ch1_irq_set", 32'(irq), 32'h1);
    wr(8'h24, 32'h1);
    check("ch1_irq_hold", 32'(irq), 32'h1);
    idle(1);
    check("ch1_irq_clear", 32'(irq), 32'h0);
    acc(1'b1, 1'b1, 8'h2C, 32'h55, 32'h100, 1'b0, "rdwr_prewrite");
    rd(8'h2C, 32'h55, "rdwr_postwrite");

    // 3. ch0 carry error, START ignored until ERR cleared
    wr(8'h0C, 32'hFFFF_FFFE);
    wr(8'h08, 32'h5);
    wr(8'h00, 32'h1);
    repeat (3) rd(8'h04, 32'h2, "ch0_busy");
    rd(8'h04, 32'h4, "ch0_err");
    rd(8'h10, 32'h0, "ch0_trunc_sum");
    wr(8'h00, 32'h1);
    rd(8'h04, 32'h4, "ch0_start_ignored");
    wr(8'h04, 32'h4);
    rd(8'h04, 32'h0, "ch0_err_w1c");
    wr(8'h08, 32'h1);
    wr(8'h00, 32'h1);
    repeat (2) rd(8'h04, 32'h2, "ch0_rearm_busy");
    rd(8'h04, 32'h1, "ch0_rearm_done");
    rd(8'h10, 32'hFFFF_FFFF, "ch0_rearm_data");
    wr(8'h04, 32'h1);

    // 4. ch2 abort at RUN cycle 2, START+ABORT stays idle
    wr(8'h4C, 32'h10);
    wr(8'h48, 32'd10);
    wr(8'h40, 32'h1);
    rd(8'h44, 32'h2, "ch2_busy");
    wr(8'h40, 32'h2);
    rd(8'h44, 32'h0, "ch2_aborted");
    rd(8'h50, 32'h10, "ch2_abort_data");
    wr(8'h40, 32'h3);
    rd(8'h44, 32'h0, "ch2_startabort_idle");
    rd(8'h44, 32'h0, "ch2_startabort_idle2");

    // 5. unmapped and read-only accesses
    acc(1'b1, 1'b0, 8'h14, 32'h0, 32'hDEAD_BEEF, 1'b1, "unmapped_14");
    acc(1'b1, 1'b0, 8'hE0, 32'h0, 32'hDEAD_BEEF, 1'b1, "unmapped_e0");
    acc(1'b0, 1'b1, 8'h10, 32'h1234, 32'h0, 1'b1, "ro_write");
    rd(8'h10, 32'hFFFF_FFFF, "ro_unchanged");
    acc(1'b0, 1'b1, 8'hF8, 32'h1, 32'h0, 1'b1, "caps_write");
    acc(1'b1, 1'b0, 8'h01, 32'h0, 32'hDEAD_BEEF, 1'b1, "unaligned");

    // 6. concurrent ch2/ch3, W1C collides with hardware DONE set
    wr(8'h48, 32'h2);
    wr(8'h6C, 32'h200);
    wr(8'h68, 32'h1);
    wr(8'h40, 32'h1);
    wr(8'h60, 32'h5);
    rd(8'h44, 32'h2, "ch2_conc_busy");
    wr(8'h64, 32'h1);
    rd(8'h64, 32'h1, "ch3_done_wins");
    rd(8'h44, 32'h1, "ch2_conc_done");
    rd(8'h70, 32'h201, "ch3_data_out");
    rd(8'h50, 32'h12, "ch2_data_out");
    check("ch3_irq", 32'(irq), 32'h1);
    wr(8'h68, 32'd50);
    wr(8'h60, 32'h5);
    idle(2);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_irq", 32'(irq), 32'h0);
    check("async_reset_rvalid", 32'(rvalid), 32'h0);
    check("async_reset_rdata", rdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(8'h64, 32'h0, "post_reset_status");
    rd(8'h70, 32'h0, "post_reset_data_out");
    rd(8'h60, 32'h0, "post_reset_ctrl");
    idle(3);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'h0);
    check("err_queue_drained", 32'(exp_err.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
